// File: rtl/axi_fft_master_pkg.sv
// axi_fft_master_pkg: shared types and constants for the FFT bridge AXI initiator.
//   master_fsm_e   : the six-state burst sequencer
//   AXSIZE_2B/4B   : beat size encodings for 16-bit writes and 32-bit reads
//   AXBURST_INCR   : incrementing burst type
package axi_fft_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddrWrite,
    StDataWrite,
    StWaitCalc,
    StAddrRead,
    StDataRead
  } master_fsm_e;

  localparam logic [2:0] AXSIZE_2B    = 3'b001;
  localparam logic [2:0] AXSIZE_4B    = 3'b010;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

endpackage

// File: rtl/axi_fft_master.sv
// axi_fft_master: AXI-style initiator for the FFT slave bridge.
// On i_START it writes one INCR burst of samples taken from the upstream stream
// (i_S_*/o_S_READY), waits for i_CALC_END, reads one INCR burst and forwards the
// results to the downstream stream (o_M_*/i_M_READY). There is no B channel.
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_START, i_BURST_LEN       start pulse and AxLEN (beats - 1) for both bursts
//   i_WR_ADDR, i_RD_ADDR       burst start addresses, captured on start
//   i_CALC_END                 FFT finished flag
//   i_S_*/o_S_READY            sample source stream
//   o_M_*/i_M_READY            result sink stream
//   o_AW*/o_W*/o_AR*/o_RREADY  AXI write address, write data, read address, read data
//   o_BUSY, o_DONE, o_LAST_ERR status: not idle, burst done pulse, sticky RLAST mismatch
module axi_fft_master
  import axi_fft_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_START,
  input  logic [7:0]              i_BURST_LEN,
  input  logic [ADDR_WIDTH-1:0]   i_WR_ADDR,
  input  logic [ADDR_WIDTH-1:0]   i_RD_ADDR,
  input  logic                    i_CALC_END,
  input  logic [SAMPLE_WIDTH-1:0] i_S_DATA,
  input  logic                    i_S_VALID,
  output logic                    o_S_READY,
  output logic [DATA_WIDTH-1:0]   o_M_DATA,
  output logic                    o_M_VALID,
  output logic                    o_M_LAST,
  input  logic                    i_M_READY,
  output logic [ADDR_WIDTH-1:0]   o_AWADDR,
  output logic [7:0]              o_AWLEN,
  output logic [2:0]              o_AWSIZE,
  output logic [1:0]              o_AWBURST,
  output logic                    o_AWVALID,
  input  logic                    i_AWREADY,
  output logic [SAMPLE_WIDTH-1:0] o_WDATA,
  output logic [1:0]              o_WSTRB,
  output logic                    o_WVALID,
  output logic                    o_WLAST,
  input  logic                    i_WREADY,
  output logic [ADDR_WIDTH-1:0]   o_ARADDR,
  output logic [7:0]              o_ARLEN,
  output logic [2:0]              o_ARSIZE,
  output logic [1:0]              o_ARBURST,
  output logic                    o_ARVALID,
  input  logic                    i_ARREADY,
  input  logic [DATA_WIDTH-1:0]   i_RDATA,
  input  logic                    i_RVALID,
  input  logic                    i_RLAST,
  output logic                    o_RREADY,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_LAST_ERR
);

  master_fsm_e           state_q;
  logic [7:0]            beat_cnt_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  done_q;
  logic                  last_err_q;

  logic cnt_last;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic r_hs;

  // 8-bit counter against 8-bit length: len 255 terminates at 255 before any wrap.
  assign cnt_last = (beat_cnt_q == len_q);
  assign aw_hs    = (state_q == StAddrWrite) && i_AWREADY;
  assign w_hs     = (state_q == StDataWrite) && i_S_VALID && i_WREADY;
  assign ar_hs    = (state_q == StAddrRead) && i_ARREADY;
  assign r_hs     = (state_q == StDataRead) && i_RVALID && i_M_READY;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      len_q      <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_START) begin
            len_q      <= i_BURST_LEN;
            wr_addr_q  <= i_WR_ADDR;
            rd_addr_q  <= i_RD_ADDR;
            beat_cnt_q <= '0;
            last_err_q <= 1'b0;
            state_q    <= StAddrWrite;
          end
        end
        StAddrWrite: begin
          if (aw_hs) state_q <= StDataWrite;
        end
        StDataWrite: begin
          if (w_hs) begin
            if (cnt_last) begin
              beat_cnt_q <= '0;
              state_q    <= StWaitCalc;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        StWaitCalc: begin
          if (i_CALC_END) state_q <= StAddrRead;
        end
        StAddrRead: begin
          if (ar_hs) state_q <= StDataRead;
        end
        StDataRead: begin
          if (r_hs) begin
            // The counter ends the burst; RLAST is only cross-checked.
            if (i_RLAST != cnt_last) last_err_q <= 1'b1;
            if (cnt_last) begin
              beat_cnt_q <= '0;
              done_q     <= 1'b1;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Channel outputs decoded from the registered state; data paths pass through
  // only in their own phase so everything reads 0 elsewhere.
  always_comb begin
    o_AWADDR  = '0;
    o_AWLEN   = '0;
    o_AWSIZE  = '0;
    o_AWBURST = '0;
    o_AWVALID = 1'b0;
    o_WDATA   = '0;
    o_WSTRB   = '0;
    o_WVALID  = 1'b0;
    o_WLAST   = 1'b0;
    o_S_READY = 1'b0;
    o_ARADDR  = '0;
    o_ARLEN   = '0;
    o_ARSIZE  = '0;
    o_ARBURST = '0;
    o_ARVALID = 1'b0;
    o_RREADY  = 1'b0;
    o_M_DATA  = '0;
    o_M_VALID = 1'b0;
    o_M_LAST  = 1'b0;
    unique case (state_q)
      StAddrWrite: begin
        o_AWADDR  = wr_addr_q;
        o_AWLEN   = len_q;
        o_AWSIZE  = AXSIZE_2B;
        o_AWBURST = AXBURST_INCR;
        o_AWVALID = 1'b1;
      end
      StDataWrite: begin
        o_WDATA   = i_S_DATA;
        o_WSTRB   = 2'b11;
        o_WVALID  = i_S_VALID;
        o_WLAST   = cnt_last;
        o_S_READY = i_WREADY;
      end
      StAddrRead: begin
        o_ARADDR  = rd_addr_q;
        o_ARLEN   = len_q;
        o_ARSIZE  = AXSIZE_4B;
        o_ARBURST = AXBURST_INCR;
        o_ARVALID = 1'b1;
      end
      StDataRead: begin
        o_RREADY  = i_M_READY;
        o_M_DATA  = i_RDATA;
        o_M_VALID = i_RVALID;
        o_M_LAST  = cnt_last;
      end
      default: ;
    endcase
  end

  assign o_BUSY     = (state_q != StIdle);
  assign o_DONE     = done_q;
  assign o_LAST_ERR = last_err_q;

endmodule

// File: tb/tb_axi_fft_master.sv
module tb_axi_fft_master;
  localparam int AW = 12;
  localparam int SW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_START;
  logic [7:0]    i_BURST_LEN;
  logic [AW-1:0] i_WR_ADDR, i_RD_ADDR;
  logic          i_CALC_END;
  logic [SW-1:0] i_S_DATA;
  logic          i_S_VALID, o_S_READY;
  logic [DW-1:0] o_M_DATA;
  logic          o_M_VALID, o_M_LAST, i_M_READY;
  logic [AW-1:0] o_AWADDR, o_ARADDR;
  logic [7:0]    o_AWLEN, o_ARLEN;
  logic [2:0]    o_AWSIZE, o_ARSIZE;
  logic [1:0]    o_AWBURST, o_ARBURST;
  logic          o_AWVALID, i_AWREADY, o_ARVALID, i_ARREADY;
  logic [SW-1:0] o_WDATA;
  logic [1:0]    o_WSTRB;
  logic          o_WVALID, o_WLAST, i_WREADY;
  logic [DW-1:0] i_RDATA;
  logic          i_RVALID, i_RLAST, o_RREADY;
  logic          o_BUSY, o_DONE, o_LAST_ERR;

  always #5 clk = ~clk;

  axi_fft_master #(.ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_START(i_START), .i_BURST_LEN(i_BURST_LEN),
    .i_WR_ADDR(i_WR_ADDR), .i_RD_ADDR(i_RD_ADDR), .i_CALC_END(i_CALC_END),
    .i_S_DATA(i_S_DATA), .i_S_VALID(i_S_VALID), .o_S_READY(o_S_READY),
    .o_M_DATA(o_M_DATA), .o_M_VALID(o_M_VALID), .o_M_LAST(o_M_LAST), .i_M_READY(i_M_READY),
    .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST),
    .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY), .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB),
    .o_WVALID(o_WVALID), .o_WLAST(o_WLAST), .i_WREADY(i_WREADY),
    .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
    .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY), .i_RDATA(i_RDATA), .i_RVALID(i_RVALID),
    .i_RLAST(i_RLAST), .o_RREADY(o_RREADY), .o_BUSY(o_BUSY), .o_DONE(o_DONE),
    .o_LAST_ERR(o_LAST_ERR)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t wq[$];
  beat_t rq[$];
  beat_t mon_w, mon_r;

  typedef struct {
    logic [7:0]    len;
    logic [AW-1:0] wr;
    logic [AW-1:0] rd;
    int            aw_dly;
    int            calc_dly;   // 0: CALC_END already high before the wait state
    int            bad_beat;   // read beat index carrying a wrong RLAST, -1 none
    bit            toggle;     // M_READY toggles every cycle
    bit            stall;      // random source / WREADY gaps
    bit            busy_start; // START pulse with junk fields while busy
    bit            exp_err;
  } case_t;

  case_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{o_S_READY, o_M_DATA, o_M_VALID, o_M_LAST, o_AWADDR, o_AWLEN, o_AWSIZE,
             o_AWBURST, o_AWVALID, o_WDATA, o_WSTRB, o_WVALID, o_WLAST, o_ARADDR,
             o_ARLEN, o_ARSIZE, o_ARBURST, o_ARVALID, o_RREADY, o_BUSY, o_DONE,
             o_LAST_ERR};
  endfunction

  // Scoreboard monitor: pops on every handshake seen between clock edges.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_DONE) done_cnt++;
      if (o_WVALID && i_WREADY) begin
        if (wq.size() == 0) check("w_unexpected_beat", 1, 0);
        else begin
          mon_w = wq.pop_front();
          check("wdata", 64'(o_WDATA), 64'(mon_w.data));
          check("wlast", 64'(o_WLAST), 64'(mon_w.last));
          check("s_ready", 64'(o_S_READY), 1);
          check("wstrb", 64'(o_WSTRB), 3);
        end
      end
      if (o_M_VALID) check("rready_mirror", 64'(o_RREADY), 64'(i_M_READY));
      if (o_M_VALID && i_M_READY) begin
        if (rq.size() == 0) check("r_unexpected_beat", 1, 0);
        else begin
          mon_r = rq.pop_front();
          check("m_data", 64'(o_M_DATA), 64'(mon_r.data));
          check("m_last", 64'(o_M_LAST), 64'(mon_r.last));
        end
      end
    end
  end

  task automatic clear_inputs();
    i_START = 0; i_BURST_LEN = 0; i_WR_ADDR = 0; i_RD_ADDR = 0; i_CALC_END = 0;
    i_S_DATA = 0; i_S_VALID = 0; i_M_READY = 0; i_AWREADY = 0; i_WREADY = 0;
    i_ARREADY = 0; i_RDATA = 0; i_RVALID = 0; i_RLAST = 0;
  endtask

  task automatic run_case(input case_t c);
    int i, n, cyc, base_done;
    bit v, r;
    logic mr;
    logic [SW-1:0] sdat;
    @(posedge clk); #1;
    i_START = 1; i_BURST_LEN = c.len; i_WR_ADDR = c.wr; i_RD_ADDR = c.rd;
    i_CALC_END = (c.calc_dly == 0);
    @(posedge clk); #1;
    // Scramble the fields after start so any late capture shows up.
    i_START = 0; i_BURST_LEN = 8'($urandom); i_WR_ADDR = AW'($urandom);
    i_RD_ADDR = AW'($urandom);
    base_done = done_cnt;
    check("aw_valid_1cyc", 64'(o_AWVALID), 1);
    check("awaddr", 64'(o_AWADDR), 64'(c.wr));
    check("awlen", 64'(o_AWLEN), 64'(c.len));
    check("awsize", 64'(o_AWSIZE), 1);
    check("awburst", 64'(o_AWBURST), 1);
    check("busy_write", 64'(o_BUSY), 1);
    check("last_err_cleared", 64'(o_LAST_ERR), 0);
    repeat (c.aw_dly) begin
      @(posedge clk); #1;
      check("aw_hold", {o_AWVALID, o_AWADDR, o_AWLEN}, {1'b1, c.wr, c.len});
    end
    i_AWREADY = 1;
    @(posedge clk); #1;
    i_AWREADY = 0;
    check("aw_drop", 64'(o_AWVALID), 0);
    i = 0;
    while (i <= int'(c.len)) begin
      v = 1; r = 1;
      if (c.stall) begin
        case ($urandom_range(0, 3))
          0: v = 0;
          1: r = 0;
          default: ;
        endcase
      end
      sdat = SW'(32'h1111 * (i + 1));
      i_S_VALID = v; i_WREADY = r; i_S_DATA = sdat;
      if (v && r) begin
        wq.push_back('{data: DW'(sdat), last: (i == int'(c.len))});
        i++;
      end
      @(posedge clk); #1;
    end
    i_S_VALID = 0; i_WREADY = 0;
    check("wq_drained", 64'(wq.size()), 0);
    if (c.calc_dly > 0) begin
      for (int k = 0; k < c.calc_dly; k++) begin
        check("ar_early", 64'(o_ARVALID), 0);
        check("busy_wait", 64'(o_BUSY), 1);
        i_START = c.busy_start && (k == 0);
        if (i_START) begin
          i_BURST_LEN = 8'h07; i_WR_ADDR = ~c.wr; i_RD_ADDR = ~c.rd;
        end
        @(posedge clk); #1;
        i_START = 0;
      end
      i_CALC_END = 1;
    end
    n = 0;
    while (!o_ARVALID && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ar_seen", 64'(o_ARVALID), 1);
    i_CALC_END = 0;
    check("araddr", 64'(o_ARADDR), 64'(c.rd));
    check("arlen", 64'(o_ARLEN), 64'(c.len));
    check("arsize", 64'(o_ARSIZE), 2);
    check("arburst", 64'(o_ARBURST), 1);
    i_ARREADY = 1;
    @(posedge clk); #1;
    i_ARREADY = 0;
    i = 0; cyc = 0;
    while (i <= int'(c.len)) begin
      mr = c.toggle ? logic'(cyc % 2) : 1'b1;
      cyc++;
      i_RVALID = 1; i_RDATA = DW'(32'hA + i); i_M_READY = mr;
      i_RLAST = (i == int'(c.len)) ^ (i == c.bad_beat);
      if (mr) begin
        rq.push_back('{data: DW'(32'hA + i), last: (i == int'(c.len))});
        i++;
      end
      @(posedge clk); #1;
    end
    i_RVALID = 0; i_RLAST = 0; i_M_READY = 0;
    check("rq_drained", 64'(rq.size()), 0);
    check("done_pulse", 64'(o_DONE), 1);
    check("busy_idle", 64'(o_BUSY), 0);
    check("last_err", 64'(o_LAST_ERR), 64'(c.exp_err));
    @(posedge clk); #1;
    check("done_drop", 64'(o_DONE), 0);
    check("last_err_sticky", 64'(o_LAST_ERR), 64'(c.exp_err));
    check("done_count", 64'(done_cnt - base_done), 1);
  endtask

  initial begin
    tbl[0] = '{len: 8'd3, wr: 12'h010, rd: 12'h020, aw_dly: 2, calc_dly: 10, bad_beat: -1,
               toggle: 0, stall: 0, busy_start: 1, exp_err: 0};
    tbl[1] = '{len: 8'd3, wr: 12'h010, rd: 12'h020, aw_dly: 0, calc_dly: 0, bad_beat: -1,
               toggle: 1, stall: 1, busy_start: 0, exp_err: 0};
    tbl[2] = '{len: 8'd0, wr: 12'h100, rd: 12'h200, aw_dly: 1, calc_dly: 3, bad_beat: -1,
               toggle: 0, stall: 0, busy_start: 0, exp_err: 0};
    tbl[3] = '{len: 8'd3, wr: 12'h030, rd: 12'h040, aw_dly: 0, calc_dly: 2, bad_beat: 1,
               toggle: 0, stall: 1, busy_start: 0, exp_err: 1};
    tbl[4] = '{len: 8'd5, wr: 12'h050, rd: 12'h060, aw_dly: 0, calc_dly: 1, bad_beat: -1,
               toggle: 1, stall: 0, busy_start: 0, exp_err: 0};
    tbl[5] = '{len: 8'd255, wr: 12'hFF0, rd: 12'h0F0, aw_dly: 0, calc_dly: 2, bad_beat: -1,
               toggle: 0, stall: 0, busy_start: 0, exp_err: 0};

    clear_inputs();
    rstn = 0;
    // Upstream inputs active during reset must not leak to the outputs.
    i_S_VALID = 1; i_WREADY = 1; i_RVALID = 1; i_M_READY = 1; i_S_DATA = 16'hFFFF;
    i_RDATA = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(any_out()), 0);
    clear_inputs();
    rstn = 1;
    @(posedge clk); #1;
    check("idle_after_reset", 64'(o_BUSY), 0);

    for (int t = 0; t < 6; t++) run_case(tbl[t]);

    // Reset during the third write beat, then a fresh burst.
    @(posedge clk); #1;
    i_START = 1; i_BURST_LEN = 8'd3; i_WR_ADDR = 12'h070; i_RD_ADDR = 12'h080;
    @(posedge clk); #1;
    i_START = 0; i_AWREADY = 1;
    @(posedge clk); #1;
    i_AWREADY = 0; i_WREADY = 1;
    for (int b = 0; b < 2; b++) begin
      i_S_VALID = 1; i_S_DATA = SW'(32'h1111 * (b + 1));
      wq.push_back('{data: DW'(32'h1111 * (b + 1)), last: 1'b0});
      @(posedge clk); #1;
    end
    i_S_DATA = 16'h3333;
    check("wvalid_beat2", 64'(o_WVALID), 1);
    #1 rstn = 0;
    #1;
    check("mid_reset_outputs", 64'(any_out()), 0);
    check("mid_reset_wq", 64'(wq.size()), 0);
    wq.delete();
    clear_inputs();
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
    check("idle_after_mid_reset", 64'(any_out()), 0);
    run_case(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
